oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 120 ++++++++++++
 tb/tb_oam_dma.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: copies COUNT bytes from {src_hi,00} to OAM_BASE.
// A CPU store to DMA_REG starts a transfer, or restarts one already running.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'hff46,
  parameter logic [15:0] OAM_BASE = 16'hfe00,
  parameter int          COUNT    = 160
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  input  logic [7:0]  dma_indata,
  output logic [7:0]  dma_outdata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  r_src_hi;
  logic        r_rd_sel;
  logic        w_sel_wr;
  logic        w_sel_rd;
  logic [7:0]  w_eff_hi;
  logic [15:0] w_src_addr;
  logic [15:0] w_dst_addr;

  assign w_sel_wr = store && (address == DMA_REG);
  assign w_sel_rd = load && (address == DMA_REG);

  // Echo RAM at e000-fdff mirrors c000-ddff.
  assign w_eff_hi = (r_src_hi >= 8'he0) ? (r_src_hi - 8'h20) : r_src_hi;

  assign w_src_addr = {w_eff_hi, 8'h00} + {8'h00, r_idx};
  assign w_dst_addr = OAM_BASE + {8'h00, r_idx};

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_idx    <= 8'h00;
      r_src_hi <= 8'h00;
      r_rd_sel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rd_sel <= w_sel_rd;
      if (w_sel_wr)
        r_src_hi <= indata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_sel_wr) begin
      w_state_nxt = READ;
      w_idx_nxt   = 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        READ: begin
          w_state_nxt = WRITE;
        end
        WRITE: begin
          if (r_idx == LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = READ;
            w_idx_nxt   = r_idx + 8'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dma_address = 16'h0000;
    dma_outdata = 8'h00;
    dma_load    = 1'b0;
    dma_store   = 1'b0;
    unique case (r_state)
      READ: begin
        dma_address = w_src_addr;
        dma_load    = 1'b1;
      end
      WRITE: begin
        dma_address = w_dst_addr;
        dma_store   = 1'b1;
        dma_outdata = dma_indata;
      end
      default: begin
        dma_address = 16'h0000;
      end
    endcase
  end

  assign busy    = (r_state != IDLE);
  assign outdata = r_rd_sel ? r_src_hi : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma with a cycle-indexed transfer model
// and a random-content source memory.
module tb_oam_dma;

  localparam logic [15:0] DMA_REG  = 16'hff46;
  localparam logic [15:0] OAM_BASE = 16'hfe00;
  localparam int          COUNT    = 160;

  logic        clockgb;
  logic        resetn;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic [15:0] dma_address;
  logic [7:0]  dma_indata;
  logic [7:0]  dma_outdata;
  logic        dma_load;
  logic        dma_store;
  logic        busy;

  oam_dma #(
    .DMA_REG  (DMA_REG),
    .OAM_BASE (OAM_BASE),
    .COUNT    (COUNT)
  ) dut (
    .clockgb     (clockgb),
    .resetn      (resetn),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata),
    .load        (load),
    .store       (store),
    .dma_address (dma_address),
    .dma_indata  (dma_indata),
    .dma_outdata (dma_outdata),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .busy        (busy)
  );

  initial clockgb = 1'b0;
  always #5 clockgb = ~clockgb;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  logic [7:0] mem [65536];
  logic [7:0] oam [256];

  always @(posedge clockgb)
    if (dma_load)
      dma_indata <= mem[dma_address];

  // Model: a transfer started at edge m_start occupies cycles k=0..2*COUNT-1
  // after that edge; even k reads byte k/2, odd k writes it.
  int         cyc = 0;
  int         m_start = 0;
  logic       m_active = 1'b0;
  logic [7:0] m_hi = 8'h00;
  logic       m_rdv = 1'b0;

  always @(posedge clockgb) begin
    cyc = cyc + 1;
    if (!resetn) begin
      m_active = 1'b0;
      m_hi     = 8'h00;
      m_rdv    = 1'b0;
    end else begin
      m_rdv = load && (address == DMA_REG);
      if (store && address == DMA_REG) begin
        m_hi     = indata;
        m_start  = cyc;
        m_active = 1'b1;
      end
    end
  end

  always @(negedge clockgb) begin
    int          k;
    logic [7:0]  eh;
    logic [15:0] ra;
    logic [26:0] exp;
    logic [26:0] got;
    got = {busy, dma_load, dma_store, dma_address, dma_outdata};
    exp = '0;
    k   = cyc - m_start;
    if (resetn && m_active && k >= 0 && k < 2 * COUNT) begin
      eh = (m_hi >= 8'he0) ? m_hi - 8'h20 : m_hi;
      ra = {eh, 8'h00} + 16'(k / 2);
      if (k % 2 == 0)
        exp = {3'b110, ra, 8'h00};
      else
        exp = {3'b101, OAM_BASE + 16'(k / 2), mem[ra]};
    end
    chk("bus", {5'b0, got}, {5'b0, exp});
    chk("cpu_rd", {24'b0, outdata},
        {24'b0, (resetn && m_rdv) ? m_hi : 8'h00});
    if (dma_store && dma_address[15:8] == 8'hfe)
      oam[dma_address[7:0]] = dma_outdata;
  end

  task automatic step();
    @(posedge clockgb);
    #1;
  endtask

  task automatic cpu_store(input logic [15:0] a, input logic [7:0] d);
    address = a;
    indata  = d;
    store   = 1'b1;
    step();
    store   = 1'b0;
    address = 16'h0000;
    indata  = 8'h00;
  endtask

  task automatic cpu_load(input logic [15:0] a);
    address = a;
    load    = 1'b1;
    step();
    load    = 1'b0;
    address = 16'h0000;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin
      step();
      t++;
    end
    chk("idle_to", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_wr(input logic [15:0] a);
    int t;
    t = 0;
    while (!(dma_store && dma_address == a) && t < 1000) begin
      step();
      t++;
    end
    chk("wait_wr", {31'b0, dma_store && dma_address == a}, 32'd1);
  endtask

  task automatic chk_oam(input string tag, input logic [15:0] base);
    int bad;
    bad = 0;
    for (int j = 0; j < COUNT; j++)
      if (oam[j] !== mem[base + 16'(j)])
        bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int nb;
    int nl;
    int ns;
    int n41;
    logic [15:0] last_wr;
    logic [15:0] ra;
    logic [7:0]  hi;

    for (int a = 0; a < 65536; a++)
      mem[a] = 8'($urandom);
    resetn  = 1'b0;
    address = 16'h0000;
    indata  = 8'h00;
    load    = 1'b0;
    store   = 1'b0;
    #1;
    chk("rst_out", {busy, dma_load, dma_store, dma_address, dma_outdata,
                    outdata}, 32'd0);
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Full transfer from c100
    cpu_store(DMA_REG, 8'hc1);
    chk("first_rd", {15'b0, dma_load, dma_address}, {15'b0, 1'b1, 16'hc100});
    nb = 0; nl = 0; ns = 0;
    repeat (330) begin
      nb += int'(busy);
      nl += int'(dma_load);
      ns += int'(dma_store);
      step();
    end
    chk("busy_cyc", nb, 320);
    chk("n_loads", nl, COUNT);
    chk("n_stores", ns, COUNT);
    chk_oam("oam_c1", 16'hc100);

    // Register readback
    cpu_load(DMA_REG);
    chk("rd_ff46", {24'b0, outdata}, 32'h0000_00c1);
    cpu_load(16'hff47);
    chk("rd_ff47", {24'b0, outdata}, 32'd0);

    // Echo-RAM source
    cpu_store(DMA_REG, 8'hf2);
    chk("echo_rd", {15'b0, dma_load, dma_address}, {15'b0, 1'b1, 16'hd200});
    wait_idle();
    chk_oam("oam_f2", 16'hd200);

    // Restart during a write
    cpu_store(DMA_REG, 8'h80);
    wait_wr(16'hfe40);
    cpu_store(DMA_REG, 8'h90);
    chk("restart_rd", {15'b0, dma_load, dma_address},
        {15'b0, 1'b1, 16'h9000});
    n41 = 0;
    last_wr = 16'h0000;
    while (busy && n41 < 1000) begin
      if (dma_store) begin
        last_wr = dma_address;
        if (dma_address == 16'hfe41) n41 += 1;
      end
      step();
    end
    chk("fe41_once", n41, 1);
    chk("last_wr", {16'b0, last_wr}, 32'h0000_fe9f);
    chk_oam("oam_90", 16'h9000);

    // Reset during a write
    cpu_store(DMA_REG, 8'h40);
    wait_wr(16'hfe10);
    resetn = 1'b0;
    #1;
    chk("rst_mid", {busy, dma_load, dma_store, dma_address, dma_outdata,
                    outdata}, 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    nb = 0;
    repeat (400) begin
      nb += int'(busy || dma_load || dma_store);
      step();
    end
    chk("post_rst", nb, 0);
    cpu_load(DMA_REG);
    chk("src_rst", {24'b0, outdata}, 32'd0);

    // Random traffic with occasional restarts
    for (int r = 0; r < 8; r++) begin
      hi = 8'($urandom);
      cpu_store(DMA_REG, hi);
      for (int c = 0; c < int'($urandom_range(100, 400)); c++) begin
        ra = 16'($urandom);
        if (ra == DMA_REG) ra = ra ^ 16'h0001;
        case ($urandom_range(0, 39))
          0: cpu_store(DMA_REG, 8'($urandom));
          1: cpu_load(DMA_REG);
          2: cpu_load(ra);
          3: cpu_store(ra, 8'($urandom));
          default: step();
        endcase
      end
      wait_idle();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
